// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer on the 27 MHz reference clock: pulses the rPLL reset, qualifies lock, releases the core reset.
// Optional dynamic divider reprogramming (cfg_* / pll_*sel ports) is enabled by defining PLL_SEQ_DYN_DIV_EN.
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES          = 27,
    parameter int unsigned LOCK_STABLE_CYCLES  = 2700,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 270000,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       restart,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_count
`ifdef PLL_SEQ_DYN_DIV_EN
    ,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [5:0] cfg_idsel,
    input  logic [5:0] cfg_fbdsel,
    input  logic [5:0] cfg_odsel,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel
`endif
);

    localparam logic [2:0] S_RESET_PLL = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
    localparam int STB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES + 1) : 1;
    localparam int TO_W  = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES + 1) : 1;

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       MAX_R    = 2'(MAX_RETRIES);

    logic             lock_meta, lock_s;
    logic [2:0]       state, state_n;
    logic [RST_W-1:0] rst_cnt, rst_cnt_n;
    logic [STB_W-1:0] stable_cnt, stable_cnt_n;
    logic [TO_W-1:0]  timeout_cnt, timeout_cnt_n;
    logic [1:0]       retry_n;
    logic             timeout_hit;

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    assign timeout_hit = (timeout_cnt == TO_LAST);

    always_comb begin
        state_n       = state;
        rst_cnt_n     = rst_cnt;
        stable_cnt_n  = stable_cnt;
        timeout_cnt_n = timeout_cnt;
        retry_n       = retry_count;
        case (state)
            S_RESET_PLL: begin
                if (rst_cnt == RST_LAST) begin
                    state_n       = S_WAIT_LOCK;
                    rst_cnt_n     = '0;
                    timeout_cnt_n = '0;
                end else begin
                    rst_cnt_n = rst_cnt + 1'b1;
                end
            end
            S_WAIT_LOCK, S_STABLE: begin
                // Stable completion outranks timeout; a lock drop in STABLE keeps the timeout running.
                if (state == S_STABLE && lock_s && stable_cnt == STB_LAST) begin
                    state_n = S_RUN;
                end else if (timeout_hit) begin
                    if (retry_count < MAX_R) begin
                        retry_n   = retry_count + 1'b1;
                        state_n   = S_RESET_PLL;
                        rst_cnt_n = '0;
                    end else begin
                        state_n = S_FAULT;
                    end
                end else begin
                    timeout_cnt_n = timeout_cnt + 1'b1;
                    if (state == S_WAIT_LOCK) begin
                        if (lock_s) begin
                            state_n      = S_STABLE;
                            stable_cnt_n = '0;
                        end
                    end else if (!lock_s) begin
                        state_n      = S_WAIT_LOCK;
                        stable_cnt_n = '0;
                    end else begin
                        stable_cnt_n = stable_cnt + 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_n   = S_RESET_PLL;
                    retry_n   = '0;
                    rst_cnt_n = '0;
                end
            end
            S_FAULT: ;
            default: state_n = S_RESET_PLL;
        endcase
`ifdef PLL_SEQ_DYN_DIV_EN
        if (cfg_valid && cfg_ready) begin
            state_n   = S_RESET_PLL;
            retry_n   = '0;
            rst_cnt_n = '0;
        end
`endif
        if (restart) begin
            state_n       = S_RESET_PLL;
            retry_n       = '0;
            rst_cnt_n     = '0;
            stable_cnt_n  = '0;
            timeout_cnt_n = '0;
        end
    end

    // Outputs decode the next state so they change on the same edge as the state register.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state       <= S_RESET_PLL;
            rst_cnt     <= '0;
            stable_cnt  <= '0;
            timeout_cnt <= '0;
            retry_count <= '0;
            pll_reset   <= 1'b1;
            sys_reset   <= 1'b1;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_n;
            rst_cnt     <= rst_cnt_n;
            stable_cnt  <= stable_cnt_n;
            timeout_cnt <= timeout_cnt_n;
            retry_count <= retry_n;
            pll_reset   <= (state_n == S_RESET_PLL) || (state_n == S_FAULT);
            sys_reset   <= (state_n != S_RUN);
            ready       <= (state_n == S_RUN);
            fault       <= (state_n == S_FAULT);
        end
    end

`ifdef PLL_SEQ_DYN_DIV_EN
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            cfg_ready  <= 1'b0;
            pll_idsel  <= '0;
            pll_fbdsel <= '0;
            pll_odsel  <= '0;
        end else begin
            cfg_ready <= (state_n == S_RUN) || (state_n == S_FAULT);
            if (cfg_valid && cfg_ready) begin
                pll_idsel  <= cfg_idsel;
                pll_fbdsel <= cfg_fbdsel;
                pll_odsel  <= cfg_odsel;
            end
        end
    end
`endif

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences the board rPLL: drives its reset, waits for a qualified lock, then releases the core's system reset.
- Monitors lock while running; on lock loss it re-asserts the core reset and restarts the PLL.
- Retries a bounded number of times, then parks in a fault state.
- Runs on the 27 MHz board reference clock (the PLL input), so it stays clocked when the PLL is unlocked.

Parameters:
RST_CYCLES, 27, width of the pll_reset pulse in clkin cycles (1 us at 27 MHz)
LOCK_STABLE_CYCLES, 2700, consecutive synchronised-lock-high cycles required before release (100 us)
LOCK_TIMEOUT_CYCLES, 270000, cycles allowed from pll_reset deassertion to qualified lock (10 ms)
MAX_RETRIES, 3, PLL reset retries after the first attempt before FAULT (max 3; retry_count is 2 bits)

Ports:
clkin  input  1  27 MHz reference clock; sole clock
reset  input  1  asynchronous, active-high reset
restart  input  1  single-cycle request to rerun the sequence from any state
pll_lock  input  1  rPLL lock; asynchronous to clkin
pll_reset  output  1  drives rPLL RESET, active high
sys_reset  output  1  reset to the core clock domain, active high
ready  output  1  high only in RUN
fault  output  1  high only in FAULT
retry_count  output  2  retries consumed in the current sequence

Behaviour:
- Clock, reset and outputs:
  - One clock (clkin). Reset is asynchronous and active-high (reset).
  - All outputs are registered.
  - On reset: state=RESET_PLL, pll_reset=1, sys_reset=1, ready=0, fault=0, retry_count=0, all counters 0.
- Lock synchronisation:
  - pll_lock passes through a 2-flop synchroniser to give lock_s.
  - Lock-to-state latency is 2 cycles plus 1 registered-output cycle.
- States and outputs:
  - RESET_PLL: pll_reset=1, sys_reset=1. Counts RST_CYCLES cycles, then goes to WAIT_LOCK. The timeout counter is cleared on exit.
  - WAIT_LOCK: pll_reset=0, sys_reset=1. The timeout counter increments every cycle. lock_s=1 sends it to STABLE with the stable counter cleared.
  - STABLE: pll_reset=0, sys_reset=1. The stable counter increments while lock_s=1 and the timeout counter keeps running.
    - lock_s=0 sends it back to WAIT_LOCK with the stable counter cleared and the timeout counter not cleared, so a chattering lock still times out.
    - When the stable counter reaches LOCK_STABLE_CYCLES, go to RUN.
  - Timeout (WAIT_LOCK or STABLE): when the timeout counter reaches LOCK_TIMEOUT_CYCLES:
    - if retry_count < MAX_RETRIES: retry_count+1, go to RESET_PLL;
    - otherwise go to FAULT.
    - If stable completion and timeout fall in the same cycle, stable completion wins.
  - RUN: pll_reset=0, sys_reset=0, ready=1. lock_s=0 for one cycle sends it to RESET_PLL with retry_count cleared. sys_reset=1 and ready=0 are registered on that transition.
  - FAULT: pll_reset=1, sys_reset=1, fault=1, ready=0. Held until restart or reset.
- Restart and reset:
  - restart=1 in any state has top priority: next state RESET_PLL, retry_count=0, counters cleared, fault=0 next cycle.
  - restart held high keeps the block in RESET_PLL with its counter cleared.
  - reset mid-sequence: immediate asynchronous return to the reset values.
- Invariants: sys_reset=0 implies ready=1 and pll_reset=0. pll_reset and ready are never both 1.

Optional Feature:
- Macro: PLL_SEQ_DYN_DIV_EN.
- With the macro defined, the block adds these ports:
  - cfg_valid (in, 1), cfg_ready (out, 1)
  - cfg_idsel, cfg_fbdsel, cfg_odsel (in, 6 each)
  - pll_idsel, pll_fbdsel, pll_odsel (out, 6 each, registered, reset 0), wired to the rPLL dynamic selects.
- Config handshake:
  - cfg_ready=1 only in RUN and FAULT.
  - On cfg_valid and cfg_ready in the same cycle: latch the three values into the pll_* registers, clear retry_count, go to RESET_PLL.
  - The new dividers are therefore present throughout the reset pulse.
  - If restart coincides, restart is taken and the config is still latched.
- Without the macro: none of these ports exist and behaviour is as above.

Test Plan:
- Power-up, params RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=50. Release reset, raise pll_lock 10 cycles after pll_reset falls → pll_reset high exactly 4 cycles; ready=1, sys_reset=0 at 2+8+1 cycles after the lock edge.
- Lock chatter: toggle pll_lock every 5 cycles (shorter than the 8-cycle stable window) → never reaches RUN; after 50 cycles retry_count=1 and pll_reset pulses again.
- No lock, MAX_RETRIES=3 → three retries (retry_count 1,2,3), then fault=1, pll_reset=1, sys_reset=1; stays there 1000 cycles.
- In FAULT, pulse restart and then provide lock → fault=0, retry_count=0 next cycle, full sequence reaches RUN.
- In RUN, drop pll_lock for 1 cycle → sys_reset=1 and ready=0 three cycles after the drop, pll_reset pulse of 4 cycles, retry_count=0.
- PLL_SEQ_DYN_DIV_EN: in RUN, cfg_valid with idsel=3, fbdsel=2, odsel=8 → cfg_ready drops, pll_* show the values on the cycle pll_reset rises; cfg_valid in WAIT_LOCK is not accepted.
